capture_ring_buffer: RTL and testbench
======================================

Name: capture_ring_buffer

Overview:
- Downstream of the capture top: stores sample packets from its memory-write interface (packet, write enable, sample number) in an on-chip circular RAM.
- Freezes the buffer when capture completes and streams stored packets to the host readout path, oldest first, over a valid/ready handshake.
- Records where the trigger fell, so the host can align pre- and post-trigger data.

Parameters:
- PACKET_WIDTH, 32, width of one stored sample packet.
- ADDR_WIDTH, 10, RAM address width; DEPTH = 2^ADDR_WIDTH packets.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  pulse: clear buffer and enter FILL.
- freeze  in  1  pulse: stop accepting writes (capture complete or abort).
- wr_en  in  1  packet write strobe from the capture stage.
- wr_packet  in  PACKET_WIDTH  packet to store.
- wr_sample_number  in  32  sample number of wr_packet.
- trig_level  in  1  capture stage post-trigger status bit.
- rd_start  in  1  pulse: begin readout (honoured only in HOLD).
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts rd_data.
- rd_data  out  PACKET_WIDTH  packet being read.
- rd_last  out  1  qualifies the final packet of a readout.
- stored_count  out  ADDR_WIDTH+1  packets held, saturating at DEPTH.
- trig_seen  out  1  trigger observed during FILL.
- trig_offset  out  ADDR_WIDTH  readout index of the first post-trigger packet.
- trig_sample_number  out  32  sample number of that packet.
- drop_count  out  16  writes rejected outside FILL; saturates at 16'hFFFF.
- state  out  2  00 IDLE, 01 FILL, 10 HOLD, 11 READ.

Behaviour:
- Reset: state IDLE; all outputs 0; wr_ptr, rd_ptr, remaining and wrapped cleared.
- RAM contents are not reset.
- IDLE: arm -> FILL.
- FILL:
  - wr_en writes mem[wr_ptr]; wr_ptr increments modulo DEPTH.
  - stored_count increments, saturating at DEPTH.
  - wrapped is set when wr_ptr rolls from DEPTH-1 to 0.
  - Trigger capture: on the first write with trig_level=1 in this FILL (trig_seen=0):
    - trig_seen <= 1;
    - trig_ptr <= wr_ptr;
    - trig_sample_number <= wr_sample_number.
  - freeze -> HOLD.
- HOLD:
  - rd_start with stored_count>0 -> READ.
  - rd_start with stored_count=0 is ignored.
  - arm -> FILL.
- READ:
  - On entry: rd_ptr = wrapped ? wr_ptr : 0; remaining = stored_count.
  - RAM read latency is 1 cycle. An output register plus 1-entry skid buffer sustains 1 packet/clk while rd_ready=1.
  - First rd_valid appears 2 cycles after rd_start.
  - rd_data/rd_valid hold stable while rd_valid=1 and rd_ready=0.
  - A packet transfers when rd_valid & rd_ready.
  - rd_last=1 exactly on packet number stored_count.
  - The cycle after the last transfer: rd_valid=0, state HOLD. The buffer is unchanged, so a re-read is allowed.
- trig_offset = (trig_ptr - oldest_ptr) mod DEPTH, where oldest_ptr = wrapped ? wr_ptr : 0. Updated on the FILL->HOLD transition.
- If the trigger packet is overwritten by wrap before freeze, trig_seen is cleared.
- Writes outside FILL:
  - wr_en in IDLE/HOLD/READ does not touch RAM or pointers.
  - drop_count increments.
- arm in any state:
  - Clears wr_ptr, stored_count, wrapped, trig_seen, trig_offset, trig_sample_number and drop_count.
  - Aborts any readout: rd_valid=0 next cycle.
  - Enters FILL.
- Simultaneous events:
  - arm+wr_en: arm wins; the packet is neither written nor counted.
  - freeze+wr_en in FILL: the packet is written, then HOLD.
  - arm+freeze: arm wins.
  - freeze outside FILL: ignored.
  - rd_start outside HOLD: ignored.
- Reset mid-READ or mid-FILL returns to IDLE with all outputs 0 next cycle.

Test Plan:
- Reset/basic read (ADDR_WIDTH=3):
  - Stimulus: arm; write 0x10..0x14 (5 packets); freeze; rd_start; rd_ready=1.
  - Response: rd_data 0x10,0x11,0x12,0x13,0x14 on consecutive cycles; rd_last on 0x14; stored_count=5; state returns to HOLD.
- Wrap:
  - Stimulus: arm; write 0x00..0x0B (12 packets); freeze; read.
  - Response: stored_count=8; output 0x04..0x0B in order.
- Trigger offset:
  - Stimulus: ADDR_WIDTH=3; write 12 packets; trig_level rises on the write of 0x09 (sample_number 9).
  - Response: trig_seen=1; trig_offset=5; trig_sample_number=9.
  - Variant: trigger on 0x02 → trig_seen=0.
- Backpressure:
  - Stimulus: during readout, toggle rd_ready 1,0,0,1,0,1.
  - Response: no packet lost or duplicated; rd_data stable while stalled; full sequence matches the written data.
- Drops and collisions:
  - Stimulus: 3 wr_en in HOLD; arm+wr_en in the same cycle.
  - Response: drop_count=3 before the arm, then 0; stored_count=0 after the arm.
  - Stimulus: freeze+wr_en on packet 0x20.
  - Response: 0x20 is the last packet read.
- Abort/reset mid-read:
  - Stimulus: arm asserted during READ after 2 transfers.
  - Response: rd_valid=0 next cycle; state FILL.
  - Stimulus: reset asserted during READ.
  - Response: state IDLE; all outputs 0.

Source files
------------

// File: rtl/capture_ring_buffer.sv
// Circular capture buffer: records sample packets while filling, freezes, then
// streams stored packets oldest-first over valid/ready with trigger position metadata.
module capture_ring_buffer #(
    parameter int PACKET_WIDTH = 32,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    arm,
    input  logic                    freeze,
    input  logic                    wr_en,
    input  logic [PACKET_WIDTH-1:0] wr_packet,
    input  logic [31:0]             wr_sample_number,
    input  logic                    trig_level,
    input  logic                    rd_start,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [PACKET_WIDTH-1:0] rd_data,
    output logic                    rd_last,
    output logic [ADDR_WIDTH:0]     stored_count,
    output logic                    trig_seen,
    output logic [ADDR_WIDTH-1:0]   trig_offset,
    output logic [31:0]             trig_sample_number,
    output logic [15:0]             drop_count,
    output logic [1:0]              state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_HOLD = 2'b10,
        ST_READ = 2'b11
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0]     remaining_reg, remaining_next, stored_count_reg, stored_count_next;
    logic                    wrapped_reg, wrapped_next;
    logic                    trig_seen_reg, trig_seen_next, trig_done_reg, trig_done_next;
    logic [ADDR_WIDTH-1:0]   trig_ptr_reg, trig_ptr_next, trig_offset_reg, trig_offset_next;
    logic [31:0]             trig_sample_reg, trig_sample_next;
    logic [15:0]             drop_count_reg, drop_count_next;
    logic                    ram_valid_reg, ram_valid_next, ram_last_reg, ram_last_next;
    logic                    out_valid_reg, out_valid_next, out_last_reg, out_last_next;
    logic [PACKET_WIDTH-1:0] out_data_reg, out_data_next;
    logic                    skid_valid_reg, skid_valid_next, skid_last_reg, skid_last_next;
    logic [PACKET_WIDTH-1:0] skid_data_reg, skid_data_next;
    logic [PACKET_WIDTH-1:0] ram_q_reg;
    logic [PACKET_WIDTH-1:0] mem [DEPTH];

    logic                    wr_accept, pop, out_free, fetch_en, fetch_last;
    logic [ADDR_WIDTH-1:0]   fetch_addr, oldest_next;
    logic [1:0]              occupancy;

    assign wr_accept = (state_reg == ST_FILL) && wr_en && !arm;
    assign pop       = out_valid_reg && rd_ready;
    assign out_free  = !out_valid_reg || pop;
    // Packets buffered or in flight once this cycle's transfer completes.
    assign occupancy = {1'b0, out_valid_reg} + {1'b0, skid_valid_reg}
                     + {1'b0, ram_valid_reg} - {1'b0, pop};

    always_comb begin
        state_next        = state_reg;
        wr_ptr_next       = wr_ptr_reg;
        rd_ptr_next       = rd_ptr_reg;
        remaining_next    = remaining_reg;
        stored_count_next = stored_count_reg;
        wrapped_next      = wrapped_reg;
        trig_seen_next    = trig_seen_reg;
        trig_done_next    = trig_done_reg;
        trig_ptr_next     = trig_ptr_reg;
        trig_offset_next  = trig_offset_reg;
        trig_sample_next  = trig_sample_reg;
        drop_count_next   = drop_count_reg;
        out_valid_next    = out_valid_reg;
        out_last_next     = out_last_reg;
        out_data_next     = out_data_reg;
        skid_valid_next   = skid_valid_reg;
        skid_last_next    = skid_last_reg;
        skid_data_next    = skid_data_reg;
        fetch_en          = 1'b0;
        fetch_last        = 1'b0;
        fetch_addr        = rd_ptr_reg;
        oldest_next       = '0;

        if (wr_en && !arm && state_reg != ST_FILL && drop_count_reg != 16'hFFFF)
            drop_count_next = drop_count_reg + 16'd1;

        if (arm) begin
            state_next        = ST_FILL;
            wr_ptr_next       = '0;
            remaining_next    = '0;
            stored_count_next = '0;
            wrapped_next      = 1'b0;
            trig_seen_next    = 1'b0;
            trig_done_next    = 1'b0;
            trig_ptr_next     = '0;
            trig_offset_next  = '0;
            trig_sample_next  = '0;
            drop_count_next   = '0;
            out_valid_next    = 1'b0;
            out_last_next     = 1'b0;
            skid_valid_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: ;
                ST_FILL: begin
                    if (wr_accept) begin
                        wr_ptr_next = wr_ptr_reg + PTR_ONE;
                        if (wr_ptr_reg == PTR_MAX)
                            wrapped_next = 1'b1;
                        if (stored_count_reg != CNT_FULL)
                            stored_count_next = stored_count_reg + CNT_ONE;
                        // Only the first trigger of a fill is captured; losing it to wrap is final.
                        if (!trig_done_reg && trig_level) begin
                            trig_done_next   = 1'b1;
                            trig_seen_next   = 1'b1;
                            trig_ptr_next    = wr_ptr_reg;
                            trig_sample_next = wr_sample_number;
                        end else if (trig_seen_reg && wr_ptr_reg == trig_ptr_reg) begin
                            trig_seen_next = 1'b0;
                        end
                    end
                    if (freeze) begin
                        state_next       = ST_HOLD;
                        oldest_next      = wrapped_next ? wr_ptr_next : '0;
                        trig_offset_next = trig_seen_next ? (trig_ptr_next - oldest_next) : '0;
                    end
                end
                ST_HOLD: begin
                    if (rd_start && stored_count_reg != '0) begin
                        state_next     = ST_READ;
                        fetch_en       = 1'b1;
                        fetch_addr     = wrapped_reg ? wr_ptr_reg : '0;
                        fetch_last     = (stored_count_reg == CNT_ONE);
                        rd_ptr_next    = fetch_addr + PTR_ONE;
                        remaining_next = stored_count_reg - CNT_ONE;
                    end
                end
                ST_READ: begin
                    if (remaining_reg != '0 && occupancy < 2'd2) begin
                        fetch_en       = 1'b1;
                        fetch_addr     = rd_ptr_reg;
                        fetch_last     = (remaining_reg == CNT_ONE);
                        rd_ptr_next    = rd_ptr_reg + PTR_ONE;
                        remaining_next = remaining_reg - CNT_ONE;
                    end
                    if (pop && out_last_reg) begin
                        state_next      = ST_HOLD;
                        out_valid_next  = 1'b0;
                        out_last_next   = 1'b0;
                        skid_valid_next = 1'b0;
                    end else if (out_free) begin
                        if (skid_valid_reg) begin
                            out_valid_next  = 1'b1;
                            out_data_next   = skid_data_reg;
                            out_last_next   = skid_last_reg;
                            skid_valid_next = ram_valid_reg;
                            skid_data_next  = ram_q_reg;
                            skid_last_next  = ram_last_reg;
                        end else if (ram_valid_reg) begin
                            out_valid_next = 1'b1;
                            out_data_next  = ram_q_reg;
                            out_last_next  = ram_last_reg;
                        end else begin
                            out_valid_next = 1'b0;
                        end
                    end else if (ram_valid_reg) begin
                        // Stalled output: the packet already in flight parks in the skid slot.
                        skid_valid_next = 1'b1;
                        skid_data_next  = ram_q_reg;
                        skid_last_next  = ram_last_reg;
                    end
                end
            endcase
        end
        ram_valid_next = fetch_en;
        ram_last_next  = fetch_last;
    end

    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[wr_ptr_reg] <= wr_packet;
        if (fetch_en)
            ram_q_reg <= mem[fetch_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            remaining_reg    <= '0;
            stored_count_reg <= '0;
            wrapped_reg      <= 1'b0;
            trig_seen_reg    <= 1'b0;
            trig_done_reg    <= 1'b0;
            trig_ptr_reg     <= '0;
            trig_offset_reg  <= '0;
            trig_sample_reg  <= '0;
            drop_count_reg   <= '0;
            ram_valid_reg    <= 1'b0;
            ram_last_reg     <= 1'b0;
            out_valid_reg    <= 1'b0;
            out_last_reg     <= 1'b0;
            out_data_reg     <= '0;
            skid_valid_reg   <= 1'b0;
            skid_last_reg    <= 1'b0;
            skid_data_reg    <= '0;
        end else begin
            state_reg        <= state_next;
            wr_ptr_reg       <= wr_ptr_next;
            rd_ptr_reg       <= rd_ptr_next;
            remaining_reg    <= remaining_next;
            stored_count_reg <= stored_count_next;
            wrapped_reg      <= wrapped_next;
            trig_seen_reg    <= trig_seen_next;
            trig_done_reg    <= trig_done_next;
            trig_ptr_reg     <= trig_ptr_next;
            trig_offset_reg  <= trig_offset_next;
            trig_sample_reg  <= trig_sample_next;
            drop_count_reg   <= drop_count_next;
            ram_valid_reg    <= ram_valid_next;
            ram_last_reg     <= ram_last_next;
            out_valid_reg    <= out_valid_next;
            out_last_reg     <= out_last_next;
            out_data_reg     <= out_data_next;
            skid_valid_reg   <= skid_valid_next;
            skid_last_reg    <= skid_last_next;
            skid_data_reg    <= skid_data_next;
        end
    end

    assign rd_valid           = out_valid_reg;
    assign rd_data            = out_data_reg;
    assign rd_last            = out_valid_reg && out_last_reg;
    assign stored_count       = stored_count_reg;
    assign trig_seen          = trig_seen_reg;
    assign trig_offset        = trig_offset_reg;
    assign trig_sample_number = trig_sample_reg;
    assign drop_count         = drop_count_reg;
    assign state              = state_reg;
endmodule

// File: tb/tb_capture_ring_buffer.sv
// Directed and randomized checks of capture_ring_buffer (ADDR_WIDTH=3) against a
// queue-based model of what the buffer should hold and report.
module tb_capture_ring_buffer;
    localparam int PW = 32;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset, arm, freeze, wr_en, trig_level, rd_start, rd_ready;
    logic [PW-1:0] wr_packet;
    logic [31:0]   wr_sample_number;
    logic          rd_valid, rd_last, trig_seen;
    logic [PW-1:0] rd_data;
    logic [AW:0]   stored_count;
    logic [AW-1:0] trig_offset;
    logic [31:0]   trig_sample_number;
    logic [15:0]   drop_count;
    logic [1:0]    state;

    int tests = 0;
    int failed = 0;

    bit [31:0] m_pkt[$];
    bit [31:0] m_sn[$];
    bit        m_trg[$];
    int        m_st;
    int        m_drops;

    capture_ring_buffer #(.PACKET_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .arm(arm), .freeze(freeze), .wr_en(wr_en),
        .wr_packet(wr_packet), .wr_sample_number(wr_sample_number),
        .trig_level(trig_level), .rd_start(rd_start), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .stored_count(stored_count), .trig_seen(trig_seen), .trig_offset(trig_offset),
        .trig_sample_number(trig_sample_number), .drop_count(drop_count), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pkt.delete();
        m_sn.delete();
        m_trg.delete();
        m_drops = 0;
        m_st = 1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_clear();
    endtask

    task automatic do_freeze();
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        if (m_st == 1) m_st = 2;
    endtask

    task automatic wr(input bit [31:0] d, input bit [31:0] sn, input bit trg, input bit frz);
        wr_en = 1'b1; wr_packet = d; wr_sample_number = sn; trig_level = trg; freeze = frz;
        tick();
        wr_en = 1'b0; trig_level = 1'b0; freeze = 1'b0;
        if (m_st == 1) begin
            m_pkt.push_back(d);
            m_sn.push_back(sn);
            m_trg.push_back(trg);
            if (frz) m_st = 2;
        end else if (m_drops < 65535) begin
            m_drops++;
        end
    endtask

    task automatic check_status(input string tag);
        int n, st, first;
        bit seen;
        n = m_pkt.size();
        st = (n > DEPTH) ? DEPTH : n;
        first = -1;
        for (int i = 0; i < n; i++) if (first < 0 && m_trg[i]) first = i;
        seen = (first >= 0) && (first >= n - st);
        chk({tag, "_stored_count"}, stored_count, st);
        chk({tag, "_trig_seen"}, trig_seen, seen);
        if (seen) begin
            chk({tag, "_trig_offset"}, trig_offset, first - (n - st));
            chk({tag, "_trig_sample"}, trig_sample_number, m_sn[first]);
        end
        chk({tag, "_drop_count"}, drop_count, m_drops);
        chk({tag, "_state"}, state, m_st);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1, 2: random ready
    task automatic read_check(input string tag, input int mode);
        bit [31:0] exp_q[$];
        bit        pat[6];
        bit        stalled;
        bit [31:0] stall_d;
        int        n, st, idx, cyc;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        n = m_pkt.size();
        st = (n > DEPTH) ? DEPTH : n;
        for (int i = n - st; i < n; i++) exp_q.push_back(m_pkt[i]);
        rd_ready = 1'b0;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk({tag, "_lat1_valid"}, rd_valid, 0);
        chk({tag, "_state_read"}, state, 3);
        tick();
        chk({tag, "_lat2_valid"}, rd_valid, 1);
        idx = 0; cyc = 0; stalled = 1'b0; stall_d = '0;
        while (idx < st && cyc < 400) begin
            if (stalled) begin
                chk({tag, "_stall_valid"}, rd_valid, 1);
                chk({tag, "_stall_data"}, rd_data, stall_d);
            end
            case (mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = pat[cyc % 6];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 0) chk({tag, "_stream_valid"}, rd_valid, 1);
            stalled = 1'b0;
            if (rd_valid && rd_ready) begin
                chk({tag, "_data"}, rd_data, exp_q[idx]);
                chk({tag, "_last"}, rd_last, idx == st - 1);
                $display("[TB] %s rd idx=%0d data=%08h last=%0b", tag, idx, rd_data, rd_last);
                idx++;
            end else if (rd_valid) begin
                stalled = 1'b1;
                stall_d = rd_data;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk({tag, "_read_count"}, idx, st);
        chk({tag, "_post_valid"}, rd_valid, 0);
        chk({tag, "_post_state"}, state, 2);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_last"}, rd_last, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_stored"}, stored_count, 0);
        chk({tag, "_trig_seen"}, trig_seen, 0);
        chk({tag, "_trig_offset"}, trig_offset, 0);
        chk({tag, "_trig_sample"}, trig_sample_number, 0);
        chk({tag, "_drops"}, drop_count, 0);
    endtask

    initial begin
        int n, r, xfers, cyc;
        bit frz_last;
        reset = 1'b1; arm = 1'b0; freeze = 1'b0; wr_en = 1'b0; trig_level = 1'b0;
        rd_start = 1'b0; rd_ready = 1'b0; wr_packet = '0; wr_sample_number = '0;
        m_st = 0; m_drops = 0;
        repeat (3) tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Basic five-packet capture and read
        do_arm();
        for (int i = 0; i < 5; i++) wr(32'h10 + i, i, 1'b0, 1'b0);
        do_freeze();
        check_status("basic");
        read_check("basic", 0);

        // Wrap with trigger on 0x09
        do_arm();
        for (int i = 0; i < 12; i++) wr(i, i, i >= 9, 1'b0);
        do_freeze();
        check_status("wrap");
        chk("wrap_trig_offset_direct", trig_offset, 5);
        chk("wrap_trig_sample_direct", trig_sample_number, 9);
        read_check("wrap", 0);
        // Re-read the unchanged buffer under backpressure
        read_check("bp", 1);

        // Trigger packet overwritten by wrap
        do_arm();
        for (int i = 0; i < 12; i++) wr(i, i, i >= 2, 1'b0);
        do_freeze();
        check_status("lost_trig");
        chk("lost_trig_direct", trig_seen, 0);

        // Drops in HOLD, then arm+wr_en collision
        for (int i = 0; i < 3; i++) wr(32'hD0 + i, 0, 1'b0, 1'b0);
        chk("drops_hold", drop_count, 3);
        arm = 1'b1; wr_en = 1'b1; wr_packet = 32'h99;
        tick();
        arm = 1'b0; wr_en = 1'b0;
        model_clear();
        check_status("arm_wr");
        wr(32'h30, 1, 1'b0, 1'b0);
        wr(32'h20, 2, 1'b0, 1'b1);
        check_status("frz_wr");
        read_check("frz_wr", 0);

        // rd_start with an empty buffer is ignored
        do_arm();
        do_freeze();
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("empty_start_state", state, 2);
        tick();
        chk("empty_start_valid", rd_valid, 0);

        // Randomized captures with gaps, trigger points and random backpressure
        for (int t = 0; t < 6; t++) begin
            do_arm();
            n = $urandom_range(1, 20);
            r = $urandom_range(0, n + 2);
            frz_last = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) tick();
                wr($urandom, 1000 * t + i, i >= r, frz_last && (i == n - 1));
            end
            if (!frz_last) do_freeze();
            check_status("rand");
            read_check("rand", 2);
        end

        // Arm during readout after two transfers
        do_arm();
        for (int i = 0; i < 6; i++) wr(32'hA0 + i, i, 1'b0, 1'b0);
        do_freeze();
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        xfers = 0; cyc = 0;
        while (xfers < 2 && cyc < 20) begin
            if (rd_valid && rd_ready) xfers++;
            tick();
            cyc++;
        end
        chk("abort_xfers", xfers, 2);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        rd_ready = 1'b0;
        model_clear();
        chk("abort_valid", rd_valid, 0);
        chk("abort_state", state, 1);
        chk("abort_stored", stored_count, 0);

        // Reset during readout
        for (int i = 0; i < 6; i++) wr(32'hB0 + i, i, i >= 1, 1'b0);
        do_freeze();
        rd_ready = 1'b1;
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        check_zero("mid_reset");
        reset = 1'b0;
        rd_ready = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
